// File: rtl/clk_pkg.sv
// Shared types and modular-minute arithmetic for the time-of-day / alarm counter bank.
package clk_pkg;

  localparam int MINUTE_W = 11;

  typedef logic [MINUTE_W-1:0] minute_t;

  typedef enum logic [1:0] {
    RING_IDLE,
    RING_ACTIVE,
    RING_SNOOZED
  } ring_state_t;

  // Add 0..2 minutes and wrap once; inputs are always below the modulus.
  function automatic minute_t wrap_add(minute_t v, logic [1:0] n,
                                       logic [MINUTE_W:0] modulus = 12'd1440);
    logic [MINUTE_W:0] sum;
    sum = {1'b0, v} + {{(MINUTE_W-1){1'b0}}, n};
    if (sum >= modulus) sum = sum - modulus;
    return sum[MINUTE_W-1:0];
  endfunction

endpackage

// File: rtl/alarm_ringer.sv
// One alarm's ring/snooze FSM with its minute countdown; the SNOOZED path exists
// only when ALARM_SNOOZE_EN is defined, otherwise an increment edge acknowledges.
module alarm_ringer
  import clk_pkg::*;
#(
  parameter int RING_MINUTES = 5,
  parameter int SNOOZE_MIN   = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trigger,
  input  logic ack,
  input  logic snooze,
  input  logic tick,
  output logic ring,
  output logic consume
);

  localparam int CNT_MAX = (RING_MINUTES > SNOOZE_MIN) ? RING_MINUTES : SNOOZE_MIN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RING_LOAD = CNT_W'(RING_MINUTES);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  ring_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ring_q, ring_d;

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    consume = 1'b0;
    case (state_q)
      RING_IDLE: begin
        if (trigger) begin
          state_d = RING_ACTIVE;
          cnt_d   = RING_LOAD;
        end
      end
      RING_ACTIVE: begin
        consume = ack | snooze;
        if (ack) begin
          state_d = RING_IDLE;
`ifdef ALARM_SNOOZE_EN
        end else if (snooze) begin
          state_d = RING_SNOOZED;
          cnt_d   = CNT_W'(SNOOZE_MIN);
`else
        end else if (snooze) begin
          state_d = RING_IDLE;
`endif
        end else if (tick) begin
          cnt_d = cnt_q - ONE;
          if (cnt_q == ONE) state_d = RING_IDLE;
        end
      end
`ifdef ALARM_SNOOZE_EN
      RING_SNOOZED: begin
        // A further increment edge while snoozed is swallowed without effect.
        consume = ack | snooze;
        if (ack) begin
          state_d = RING_IDLE;
        end else if (tick) begin
          cnt_d = cnt_q - ONE;
          if (cnt_q == ONE) begin
            state_d = RING_ACTIVE;
            cnt_d   = RING_LOAD;
          end
        end
      end
`endif
      default: state_d = RING_IDLE;
    endcase
    ring_d = (state_d == RING_ACTIVE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RING_IDLE;
      cnt_q   <= '0;
      ring_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ring_q  <= ring_d;
    end
  end

  assign ring = ring_q;

endmodule

// File: rtl/target_counter_bank.sv
// Time-of-day counter, three alarm set-points and their ringers, driven by edge-detected
// reset/increment strobes. Define ALARM_SNOOZE_EN to enable the snooze behaviour.
module target_counter_bank
  import clk_pkg::*;
#(
  parameter int MINUTES_PER_DAY = 1440,
  parameter int RING_MINUTES    = 5,
  parameter int SNOOZE_MIN      = 9
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                TICK_MIN,
  input  logic                RC,
  input  logic                IC,
  input  logic                RA1,
  input  logic                IA1,
  input  logic                RA2,
  input  logic                IA2,
  input  logic                RA3,
  input  logic                IA3,
  input  logic [1:0]          S,
  output logic [MINUTE_W-1:0] DISP,
  output logic [2:0]          ALARM
);

  localparam logic [MINUTE_W:0] MOD = (MINUTE_W+1)'(MINUTES_PER_DAY);

  logic [2:0] ra_in, ia_in;
  logic       rc_hist_q, ic_hist_q;
  logic [2:0] ra_hist_q, ia_hist_q;
  logic       rc_edge, ic_edge;
  logic [2:0] ra_edge, ia_edge;
  logic [1:0] step;
  minute_t    clock_q, clock_d;
  minute_t    alarm_q [3];
  minute_t    alarm_d [3];
  minute_t    disp_q, disp_d;
  logic [2:0] trigger, consume, ring;

  assign ra_in   = {RA3, RA2, RA1};
  assign ia_in   = {IA3, IA2, IA1};
  assign rc_edge = RC & ~rc_hist_q;
  assign ic_edge = IC & ~ic_hist_q;
  assign ra_edge = ra_in & ~ra_hist_q;
  assign ia_edge = ia_in & ~ia_hist_q;

  always_comb begin
    step    = {1'b0, ic_edge} + {1'b0, TICK_MIN};
    clock_d = rc_edge ? '0 : wrap_add(clock_q, step, MOD);
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      alarm_d[k] = alarm_q[k];
      if (!consume[k]) begin
        if (ra_edge[k])      alarm_d[k] = '0;
        else if (ia_edge[k]) alarm_d[k] = wrap_add(alarm_q[k], 2'd1, MOD);
      end
    end
  end

  always_comb begin
    case (S)
      2'b00:   disp_d = clock_q;
      2'b01:   disp_d = alarm_q[0];
      2'b10:   disp_d = alarm_q[1];
      default: disp_d = alarm_q[2];
    endcase
  end

  for (genvar k = 0; k < 3; k++) begin : g_ringer
    // Only a real clock movement can fire an alarm, never an alarm edit.
    assign trigger[k] = (clock_d != clock_q) && (clock_d == alarm_q[k]);

    alarm_ringer #(
      .RING_MINUTES (RING_MINUTES),
      .SNOOZE_MIN   (SNOOZE_MIN)
    ) u_ringer (
      .clk     (CLK),
      .rst_n   (RST_N),
      .trigger (trigger[k]),
      .ack     (ra_edge[k]),
      .snooze  (ia_edge[k]),
      .tick    (TICK_MIN),
      .ring    (ring[k]),
      .consume (consume[k])
    );
  end

  // NOTE: the small value array is reset explicitly; it is plain flops, not a RAM.
  // History resets high so a strobe held through reset is not seen as a rise.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rc_hist_q <= 1'b1;
      ic_hist_q <= 1'b1;
      ra_hist_q <= 3'b111;
      ia_hist_q <= 3'b111;
      clock_q   <= '0;
      disp_q    <= '0;
      for (int k = 0; k < 3; k++) alarm_q[k] <= '0;
    end else begin
      rc_hist_q <= RC;
      ic_hist_q <= IC;
      ra_hist_q <= ra_in;
      ia_hist_q <= ia_in;
      clock_q   <= clock_d;
      disp_q    <= disp_d;
      for (int k = 0; k < 3; k++) alarm_q[k] <= alarm_d[k];
    end
  end

  assign DISP  = disp_q;
  assign ALARM = ring;

endmodule

// File: tb/tb_target_counter_bank.sv
// Directed bench for target_counter_bank: expected DISP/ALARM values are queued as
// stimulus is applied and popped for comparison once the design should have responded.
module tb_target_counter_bank;

  localparam int P_RC  = 0;
  localparam int P_IC  = 1;
  localparam int P_RA1 = 2;
  localparam int P_IA1 = 3;
  localparam int P_RA2 = 4;
  localparam int P_IA2 = 5;
  localparam int P_RA3 = 6;
  localparam int P_IA3 = 7;

  logic        CLK      = 1'b0;
  logic        RST_N    = 1'b1;
  logic        TICK_MIN = 1'b0;
  logic [7:0]  strb     = '0;
  logic [1:0]  S        = 2'b00;
  logic [10:0] DISP;
  logic [2:0]  ALARM;

  typedef struct {
    string       tag;
    bit          is_alarm;
    logic [10:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  target_counter_bank dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .TICK_MIN (TICK_MIN),
    .RC       (strb[P_RC]),
    .IC       (strb[P_IC]),
    .RA1      (strb[P_RA1]),
    .IA1      (strb[P_IA1]),
    .RA2      (strb[P_RA2]),
    .IA2      (strb[P_IA2]),
    .RA3      (strb[P_RA3]),
    .IA3      (strb[P_IA3]),
    .S        (S),
    .DISP     (DISP),
    .ALARM    (ALARM)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse(input int idx, input int n = 1);
    repeat (n) begin
      strb[idx] = 1'b1;
      cycle();
      strb[idx] = 1'b0;
      cycle();
    end
  endtask

  task automatic advance(input int n);
    TICK_MIN = 1'b1;
    repeat (n) cycle();
    TICK_MIN = 1'b0;
  endtask

  task automatic expect_out(input string tag, input bit is_alarm, input logic [10:0] val);
    exp_t e;
    e.tag      = tag;
    e.is_alarm = is_alarm;
    e.val      = val;
    sb.push_back(e);
  endtask

  task automatic check_next();
    exp_t        e;
    logic [10:0] obs;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: observed nothing queued, required an entry");
    end else begin
      e   = sb.pop_front();
      obs = e.is_alarm ? {8'b0, ALARM} : DISP;
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %0d required %0d", e.tag, obs, e.val);
      end
    end
  endtask

  initial begin
    // 1: strobes held high through reset must not act after release.
    strb = '0;
    strb[P_RC]  = 1'b1;
    strb[P_IC]  = 1'b1;
    strb[P_IA1] = 1'b1;
    strb[P_IA2] = 1'b1;
    strb[P_IA3] = 1'b1;
    #1 RST_N = 1'b0;
    repeat (3) cycle();
    expect_out("rst_disp", 0, 11'd0);
    check_next();
    expect_out("rst_alarm", 1, 11'd0);
    check_next();
    RST_N = 1'b1;
    repeat (10) cycle();
    for (int s = 0; s < 4; s++) begin
      S = 2'(s);
      expect_out($sformatf("held_through_reset_s%0d", s), 0, 11'd0);
      cycle();
      check_next();
    end
    expect_out("held_alarm", 1, 11'd0);
    check_next();
    S    = 2'b00;
    strb = '0;
    cycle();
    pulse(P_RC);
    expect_out("rc_reraise_disp", 0, 11'd0);
    cycle();
    check_next();

    // 2: wrap boundaries and RC priority.
    advance(1439);
    expect_out("clock_1439", 0, 11'd1439);
    cycle();
    check_next();
    strb[P_IC] = 1'b1;
    TICK_MIN   = 1'b1;
    cycle();
    strb[P_IC] = 1'b0;
    TICK_MIN   = 1'b0;
    expect_out("wrap_plus2", 0, 11'd1);
    cycle();
    check_next();
    strb[P_RC] = 1'b1;
    strb[P_IC] = 1'b1;
    TICK_MIN   = 1'b1;
    cycle();
    strb[P_RC] = 1'b0;
    strb[P_IC] = 1'b0;
    TICK_MIN   = 1'b0;
    expect_out("rc_to_zero_rings_all", 1, 11'd7);
    check_next();
    expect_out("rc_wins", 0, 11'd0);
    cycle();
    check_next();
    pulse(P_RA1);
    pulse(P_RA2);
    pulse(P_RA3);
    expect_out("ack_all", 1, 11'd0);
    check_next();

    // 3: alarm 1 display latency, trigger and self-clear after RING_MINUTES ticks.
    pulse(P_IA1, 420);
    S = 2'b01;
    expect_out("disp_before_edge", 0, 11'd0);
    check_next();
    expect_out("disp_alarm1_420", 0, 11'd420);
    cycle();
    check_next();
    S = 2'b00;
    advance(419);
    expect_out("quiet_at_419", 1, 11'd0);
    check_next();
    advance(1);
    expect_out("alarm1_rings", 1, 11'd1);
    check_next();
    advance(4);
    expect_out("still_ringing_4", 1, 11'd1);
    check_next();
    advance(1);
    expect_out("self_clear_5", 1, 11'd0);
    check_next();

    // 4: acknowledge keeps the value; editing onto current time does not ring.
    pulse(P_IA2, 600);
    advance(175);
    expect_out("alarm2_rings", 1, 11'd2);
    check_next();
    pulse(P_RA2);
    expect_out("alarm2_acked", 1, 11'd0);
    check_next();
    S = 2'b10;
    expect_out("alarm2_kept_600", 0, 11'd600);
    cycle();
    check_next();
    pulse(P_IA1, 180);
    expect_out("edit_no_ring", 1, 11'd0);
    check_next();
    S = 2'b01;
    expect_out("alarm1_600", 0, 11'd600);
    cycle();
    check_next();

    // 5: increment edge while ringing.
    pulse(P_IA3, 605);
    advance(5);
    expect_out("alarm3_rings", 1, 11'd4);
    check_next();
    pulse(P_IA3);
    expect_out("alarm3_ia_stops", 1, 11'd0);
    check_next();
    S = 2'b11;
    expect_out("alarm3_kept_605", 0, 11'd605);
    cycle();
    check_next();
`ifdef ALARM_SNOOZE_EN
    advance(8);
    expect_out("snoozed_8", 1, 11'd0);
    check_next();
    advance(1);
    expect_out("snooze_rerings", 1, 11'd4);
    check_next();
    pulse(P_RA3);
    expect_out("snooze_acked", 1, 11'd0);
    check_next();
`else
    advance(12);
    expect_out("no_rering", 1, 11'd0);
    check_next();
`endif

    // 6: async reset between edges while ringing.
    pulse(P_RA1);
    pulse(P_RC);
    expect_out("rc_rings_alarm1", 1, 11'd1);
    check_next();
    S = 2'b10;
    expect_out("disp_pre_reset", 0, 11'd600);
    cycle();
    check_next();
    #3 RST_N = 1'b0;
    #1;
    expect_out("async_rst_alarm", 1, 11'd0);
    check_next();
    expect_out("async_rst_disp", 0, 11'd0);
    check_next();
    cycle();
    RST_N = 1'b1;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
